stage_if: RTL and testbench
===========================

Name: stage_if

Overview:
- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage.
- Owns the fetch PC and drives a request/valid handshake to instruction memory (IM).
- Holds one early-returning instruction while decode is stalled.
- Applies branch/jump and trap redirects, and presents {pc_o, pc4_o, inst_o} to decode, which treats pc==0 as a bubble.

Parameters:
- RESET_PC, 32'h0001_0000, boot fetch address; must be nonzero and word aligned.
- NOP_INST, 32'h0000_0013, instruction driven on inst_o during a bubble.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- hazard_stall_i  in  1  load-use stall from decode; freeze IF/ID
- MemStall_i  in  1  data-memory stall; freeze IF/ID, ignore redirects
- redirect_i  in  1  taken branch/jump from EX
- redirect_pc_i  in  32  branch/jump target
- flush_i  in  1  trap/interrupt/mret redirect from CSR
- trap_pc_i  in  32  trap/return target
- im_req_o  out  1  IM request
- im_addr_o  out  32  IM word address
- im_valid_i  in  1  IM data valid, at least 1 cycle after request
- im_rdata_i  in  32  IM instruction
- pc_o  out  32  IF/ID pc (0 means bubble)
- pc4_o  out  32  IF/ID pc+4
- inst_o  out  32  IF/ID instruction
- if_stall_o  out  1  high while no instruction is ready for IF/ID

Behaviour:
- Reset (async, any state): state=FETCH, fetch_pc=RESET_PC, hold buffer empty, pc_o=0, pc4_o=0, inst_o=NOP_INST, im_req_o=0, im_addr_o=0, if_stall_o=1.
- After reset: first cycle drives im_req_o=1, im_addr_o=RESET_PC.
- IM protocol:
  - At most one outstanding request.
  - im_req_o and im_addr_o stay stable from assertion until the cycle im_valid_i=1.
  - im_req_o drops for at least 0 cycles; the next request may start the cycle after valid.
- stall = hazard_stall_i | MemStall_i.
- redir = (flush_i | redirect_i) & ~MemStall_i.
- target = flush_i ? trap_pc_i : redirect_pc_i, with [1:0] forced to 0; flush_i wins when both are asserted.
- States:
  - FETCH: request outstanding.
  - KILL: outstanding response must be discarded.
  - HOLD: buffer full, no request.
- FETCH:
  - im_valid_i & ~stall & ~redir: IF/ID <= {fetch_pc, fetch_pc+4, im_rdata_i}; fetch_pc += 4; new request next cycle.
  - im_valid_i & stall & ~redir: buffer <= {fetch_pc, im_rdata_i}; go to HOLD; im_req_o=0.
  - ~im_valid_i & ~stall: IF/ID <= bubble (pc 0, NOP_INST); if_stall_o=1.
- HOLD: when ~stall, IF/ID <= buffer; fetch_pc += 4; go to FETCH and request fetch_pc.
- redir, any state:
  - fetch_pc <= target; IF/ID <= bubble (overrides stall); buffer cleared.
  - From FETCH with no valid this cycle: go to KILL.
  - From FETCH with valid this cycle, or from HOLD: response dropped; go to FETCH and request target next cycle.
- KILL: request held until im_valid_i; data dropped; then FETCH with im_addr_o=target.
  - A further redir in KILL updates fetch_pc only.
- Any stall without redir: IF/ID holds its value unchanged.
- fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- pc4_o is always pc_o+4 for valid entries and 0 for bubbles.

Test Plan:
- Reset with 1-cycle IM: release rst -> im_addr_o=0x10000, 0x10004, 0x10008 on successive requests; pc_o sequence 0x10000, 0x10004, … with inst_o matching memory.
- IM valid in the same cycle hazard_stall_i=1 for 3 cycles:
  - IF/ID frozen; im_req_o=0.
  - First cycle after stall: pc_o = buffered pc.
  - Next request at buffered pc+4; no instruction lost or duplicated.
- redirect_i, redirect_pc_i=0x10102, while a 4-cycle IM request to 0x10008 is pending:
  - KILL state; 0x10008 data discarded.
  - Next im_addr_o=0x10100; IF/ID shows bubble pc_o=0, inst_o=0x13 meanwhile.
- flush_i & redirect_i in the same cycle, trap_pc_i=0x20000: fetch goes to 0x20000.
- redirect_i held during MemStall_i=1: no change until MemStall drops; redirect applied once after.
- Async rst asserted while in HOLD: all outputs reset immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/stage_if.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Issues one IM request at a time, buffers an early response under stall, applies redirects.

module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall_i,
    input  logic        MemStall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        flush_i,
    input  logic [31:0] trap_pc_i,
    output logic        im_req_o,
    output logic [31:0] im_addr_o,
    input  logic        im_valid_i,
    input  logic [31:0] im_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o,
    output logic        if_stall_o
);

    typedef enum logic [1:0] {
        StFetch,
        StKill,
        StHold
    } state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] buf_inst_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic [31:0] inst_q;
    logic [31:0] im_addr_q;
    logic        im_req_q;
    logic        if_stall_q;

    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic [31:0] fetch_pc4;

    assign stall     = hazard_stall_i | MemStall_i;
    // A data-memory stall freezes the whole front end, so redirects wait for it.
    assign redir     = (flush_i | redirect_i) & ~MemStall_i;
    assign target    = (flush_i ? trap_pc_i : redirect_pc_i) & 32'hFFFF_FFFC;
    assign fetch_pc4 = fetch_pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            buf_inst_q <= NOP_INST;
            pc_q       <= '0;
            pc4_q      <= '0;
            inst_q     <= NOP_INST;
            im_req_q   <= 1'b0;
            im_addr_q  <= '0;
            if_stall_q <= 1'b1;
        end else if (redir) begin
            fetch_pc_q <= target;
            buf_inst_q <= NOP_INST;
            pc_q       <= '0;
            pc4_q      <= '0;
            inst_q     <= NOP_INST;
            if_stall_q <= 1'b1;
            if (state_q == StKill) begin
                // Still waiting out the stale response; only the target moves.
                if (im_valid_i) begin
                    state_q   <= StFetch;
                    im_addr_q <= target;
                end
            end else if (state_q == StFetch && im_req_q && !im_valid_i) begin
                state_q <= StKill;
            end else begin
                state_q   <= StFetch;
                im_req_q  <= 1'b1;
                im_addr_q <= target;
            end
        end else begin
            if_stall_q <= 1'b1;
            unique case (state_q)
                StFetch: begin
                    if (!im_req_q) begin
                        im_req_q  <= 1'b1;
                        im_addr_q <= fetch_pc_q;
                        if (!stall) begin
                            pc_q   <= '0;
                            pc4_q  <= '0;
                            inst_q <= NOP_INST;
                        end
                    end else if (im_valid_i) begin
                        if_stall_q <= 1'b0;
                        if (!stall) begin
                            pc_q       <= fetch_pc_q;
                            pc4_q      <= fetch_pc4;
                            inst_q     <= im_rdata_i;
                            fetch_pc_q <= fetch_pc4;
                            im_addr_q  <= fetch_pc4;
                        end else begin
                            buf_inst_q <= im_rdata_i;
                            im_req_q   <= 1'b0;
                            state_q    <= StHold;
                        end
                    end else if (!stall) begin
                        pc_q   <= '0;
                        pc4_q  <= '0;
                        inst_q <= NOP_INST;
                    end
                end
                StKill: begin
                    if (im_valid_i) begin
                        state_q   <= StFetch;
                        im_addr_q <= fetch_pc_q;
                    end
                end
                StHold: begin
                    if_stall_q <= 1'b0;
                    if (!stall) begin
                        pc_q       <= fetch_pc_q;
                        pc4_q      <= fetch_pc4;
                        inst_q     <= buf_inst_q;
                        buf_inst_q <= NOP_INST;
                        fetch_pc_q <= fetch_pc4;
                        state_q    <= StFetch;
                        im_req_q   <= 1'b1;
                        im_addr_q  <= fetch_pc4;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign im_req_o   = im_req_q;
    assign im_addr_o  = im_addr_q;
    assign pc_o       = pc_q;
    assign pc4_o      = pc4_q;
    assign inst_o     = inst_q;
    assign if_stall_o = if_stall_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: behavioural IM with variable latency, in-order scoreboard of
// expected IF/ID entries, table of redirect cases and hand-written stall/kill/reset sequences.

module tb_stage_if;

    localparam logic [31:0] RESET_PC = 32'h0001_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        hazard_stall_i;
    logic        MemStall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        flush_i;
    logic [31:0] trap_pc_i;
    logic        im_req_o;
    logic [31:0] im_addr_o;
    logic        im_valid_i;
    logic [31:0] im_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] inst_o;
    logic        if_stall_o;

    stage_if #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard_stall_i(hazard_stall_i),
        .MemStall_i    (MemStall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .flush_i       (flush_i),
        .trap_pc_i     (trap_pc_i),
        .im_req_o      (im_req_o),
        .im_addr_o     (im_addr_o),
        .im_valid_i    (im_valid_i),
        .im_rdata_i    (im_rdata_i),
        .pc_o          (pc_o),
        .pc4_o         (pc4_o),
        .inst_o        (inst_o),
        .if_stall_o    (if_stall_o)
    );

    typedef struct {
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] tpc;
        logic [31:0] exp_pc;
        int          lat;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    int          im_lat = 1;
    int          im_cnt = 0;
    logic        stall_seen = 1'b0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hC3C3_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start);
        logic [31:0] p;
        exp_q.delete();
        for (int k = 0; k < 48; k++) begin
            p = start + 32'(4 * k);
            if (p != 32'd0) exp_q.push_back(p);
        end
    endtask

    task automatic wait_pops(input int n, input string name);
        int goal;
        int t;
        goal = pops + n;
        t = 0;
        while (pops < goal && t < 120) begin
            tick();
            t++;
        end
        check(name, 32'(pops >= goal), 32'd1);
    endtask

    task automatic wait_addr(input logic [31:0] a, input string name);
        int t;
        t = 0;
        while (!(im_req_o && im_addr_o == a) && t < 40) begin
            tick();
            t++;
        end
        check(name, im_addr_o, a);
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!im_valid_i && t < 40) begin
            tick();
            t++;
        end
        check(name, 32'(im_valid_i), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, pc_o, 32'd0);
        check({tag, "_pc4"}, pc4_o, 32'd0);
        check({tag, "_inst"}, inst_o, NOP_INST);
        check({tag, "_req"}, 32'(im_req_o), 32'd0);
        check({tag, "_addr"}, im_addr_o, 32'd0);
        check({tag, "_if_stall"}, 32'(if_stall_o), 32'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: answers each request after im_lat cycles of im_req_o.
    initial begin
        logic [31:0] a;
        im_valid_i = 1'b0;
        im_rdata_i = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                im_cnt = 0;
                #1 im_valid_i = 1'b0;
            end else if (im_valid_i) begin
                im_cnt = 0;
                #1 im_valid_i = 1'b0;
            end else if (im_req_o) begin
                im_cnt++;
                if (im_cnt >= im_lat) begin
                    a = im_addr_o;
                    #1;
                    im_valid_i = 1'b1;
                    im_rdata_i = mem_f(a);
                end
            end
        end
    end

    always @(posedge clk) stall_seen <= hazard_stall_i | MemStall_i;

    // An unstalled edge loads a new IF/ID entry; nonzero pc entries must follow exp_q.
    always @(negedge clk) begin
        if (!rst && !stall_seen) begin
            if (pc_o != 32'd0) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_entry", pc_o, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    pops++;
                    check("sb_pc", pc_o, e);
                    check("sb_pc4", pc4_o, e + 32'd4);
                    check("sb_inst", inst_o, mem_f(e));
                end
            end else if (pc4_o == 32'd0) begin
                check("sb_bubble_inst", inst_o, NOP_INST);
            end
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, expected end before 400000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] prev;
        logic [31:0] buffered;
        logic [31:0] pc_before;
        logic [31:0] frozen;
        int          t;

        vecs[0] = '{1'b0, 1'b1, 32'h0004_0000, 32'h0009_0000, 32'h0004_0000, 1};
        vecs[1] = '{1'b1, 1'b1, 32'h0005_0000, 32'h0002_0000, 32'h0002_0000, 2};
        vecs[2] = '{1'b1, 1'b0, 32'h0006_0000, 32'h0003_0007, 32'h0003_0004, 3};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF8, 1};
        vecs[4] = '{1'b0, 1'b1, 32'h0001_2346, 32'h0007_0000, 32'h0001_2344, 2};

        rst            = 1'b1;
        hazard_stall_i = 1'b0;
        MemStall_i     = 1'b0;
        redirect_i     = 1'b0;
        redirect_pc_i  = '0;
        flush_i        = 1'b0;
        trap_pc_i      = '0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Boot sequence with a 1-cycle IM.
        push_stream(RESET_PC);
        rst = 1'b0;
        t = 0;
        while (!im_req_o && t < 10) begin
            tick();
            t++;
        end
        check("boot_addr", im_addr_o, RESET_PC);
        for (int i = 0; i < 2; i++) begin
            prev = im_addr_o;
            t = 0;
            while (im_addr_o == prev && t < 20) begin
                tick();
                t++;
            end
            check("boot_seq_addr", im_addr_o, prev + 32'd4);
        end
        wait_pops(5, "boot_stream");

        // Response arrives together with a 3-cycle load-use stall.
        wait_valid("stall_align");
        buffered  = im_addr_o;
        pc_before = pc_o;
        hazard_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_frozen_pc", pc_o, pc_before);
            check("stall_no_req", 32'(im_req_o), 32'd0);
        end
        hazard_stall_i = 1'b0;
        tick();
        check("stall_release_pc", pc_o, buffered);
        check("stall_next_addr", im_addr_o, buffered + 32'd4);
        check("stall_next_req", 32'(im_req_o), 32'd1);
        wait_pops(3, "stall_stream");

        // Redirect while a slow request to 0x10008 is outstanding.
        rst = 1'b1;
        tick();
        tick();
        im_lat = 4;
        push_stream(RESET_PC);
        rst = 1'b0;
        t = 0;
        while (!(im_req_o && im_addr_o == 32'h0001_0008) && t < 80) begin
            tick();
            t++;
        end
        check("kill_pending_addr", im_addr_o, 32'h0001_0008);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0001_0102;
        push_stream(32'h0001_0100);
        tick();
        redirect_i = 1'b0;
        check("kill_bubble_pc", pc_o, 32'd0);
        check("kill_bubble_pc4", pc4_o, 32'd0);
        check("kill_bubble_inst", inst_o, NOP_INST);
        check("kill_if_stall", 32'(if_stall_o), 32'd1);
        check("kill_addr_held", im_addr_o, 32'h0001_0008);
        check("kill_req_held", 32'(im_req_o), 32'd1);
        t = 0;
        while (im_addr_o == 32'h0001_0008 && t < 20) begin
            tick();
            t++;
        end
        check("kill_new_addr", im_addr_o, 32'h0001_0100);
        check("kill_still_bubble", pc_o, 32'd0);
        im_lat = 1;
        wait_pops(3, "kill_stream");

        // Table of redirect/flush cases applied during streaming.
        for (int i = 0; i < 5; i++) begin
            im_lat = vecs[i].lat;
            repeat (3 + i) tick();
            redirect_i    = vecs[i].redirect;
            flush_i       = vecs[i].flush;
            redirect_pc_i = vecs[i].rpc;
            trap_pc_i     = vecs[i].tpc;
            push_stream(vecs[i].exp_pc);
            tick();
            redirect_i = 1'b0;
            flush_i    = 1'b0;
            check("vec_bubble", pc_o, 32'd0);
            wait_addr(vecs[i].exp_pc, "vec_target_addr");
            wait_pops(4, "vec_stream");
        end
        im_lat = 1;

        // Redirect held across a data-memory stall takes effect only afterwards.
        tick();
        MemStall_i = 1'b1;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0005_0000;
        frozen = pc_o;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("memstall_frozen_pc", pc_o, frozen);
            check("memstall_no_redir", 32'(im_addr_o == 32'h0005_0000), 32'd0);
        end
        MemStall_i = 1'b0;
        push_stream(32'h0005_0000);
        tick();
        redirect_i = 1'b0;
        check("memstall_redir_bubble", pc_o, 32'd0);
        wait_addr(32'h0005_0000, "memstall_target_addr");
        wait_pops(3, "memstall_stream");

        // Asynchronous reset while holding a buffered instruction.
        wait_valid("hold_align");
        hazard_stall_i = 1'b1;
        tick();
        check("hold_no_req", 32'(im_req_o), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_outputs("hold_reset");
        hazard_stall_i = 1'b0;
        tick();
        tick();
        push_stream(RESET_PC);
        rst = 1'b0;
        wait_addr(RESET_PC, "hold_reset_boot_addr");
        wait_pops(3, "hold_reset_stream");

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
